mult32_seq_ctrl: RTL and testbench



---
 rtl/mult32_seq_ctrl_pkg.sv | 36 +++
 rtl/mult32_datapath.sv | 104 ++++++++++
 rtl/mult32_seq_ctrl.sv | 117 +++++++++++
 tb/tb_mult32_seq_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult32_seq_ctrl_pkg.sv
// ============================================================================
// Module      : mult32_seq_ctrl_pkg
// Description : Shared definitions for the sequential 32x32 multiplier.
//               Holds the controller state encodings, the operand and
//               product widths, and the control-strobe bundle passed from
//               the controller to the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult32_seq_ctrl_pkg;

  localparam int WORD_WIDTH  = 32;
  localparam int DWORD_WIDTH = 64;

  // Controller state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // Strobes from the controller to the datapath
  typedef struct packed {
    logic load;    // capture operand magnitudes, clear product and count
    logic step;    // one shift-and-add iteration
    logic negate;  // apply the sign fix-up to the product
  } mult_ctrl_t;

  // BUSY covers the iterating and fix-up states
  function automatic logic is_busy_state(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_FIX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult32_datapath.sv
// ============================================================================
// Module      : mult32_datapath
// Description : Shift-and-add datapath for the sequential multiplier.
//               Holds the shifted multiplicand, the remaining multiplier
//               bits, the running product, the iteration count and the
//               result sign. Operands are reduced to magnitudes on load and
//               the sign is applied once at the end.
// Ports       : clk_i, rst_i         - clock, synchronous active-high reset
//               load_i/step_i/negate_i - control strobes from the FSM
//               signed_i, a_i, b_i   - operand mode and operands (on load)
//               prod_o               - running / final product
//               mplr_nz_o            - OR-reduction of remaining multiplier
//               last_o               - current iteration is the final one
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult32_datapath
  import mult32_seq_ctrl_pkg::*;
#(
  parameter int WIDTH  = WORD_WIDTH,
  parameter int PWIDTH = DWORD_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              negate_i,
  input  logic              signed_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  output logic [PWIDTH-1:0] prod_o,
  output logic              mplr_nz_o,
  output logic              last_o
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [WIDTH-1:0]  C_ONE_W    = WIDTH'(1);
  localparam logic [PWIDTH-1:0] C_ONE_P    = PWIDTH'(1);
  localparam logic [CW-1:0]     C_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     C_CNT_LAST = CW'(WIDTH - 1);

  logic [PWIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplr_q,  mplr_d;
  logic [PWIDTH-1:0] prod_q,  prod_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic              neg_q,   neg_d;

  logic [WIDTH-1:0]  w_a_mag;
  logic [WIDTH-1:0]  w_b_mag;

  // Two's-complement magnitude, kept as an unsigned WIDTH-bit value so the
  // most negative operand maps to 2^(WIDTH-1) without overflow.
  assign w_a_mag = (signed_i && a_i[WIDTH-1]) ? (~a_i + C_ONE_W) : a_i;
  assign w_b_mag = (signed_i && b_i[WIDTH-1]) ? (~b_i + C_ONE_W) : b_i;

  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    if (load_i) begin
      mcand_d = {{(PWIDTH-WIDTH){1'b0}}, w_a_mag};
      mplr_d  = w_b_mag;
      prod_d  = '0;
      cnt_d   = '0;
      neg_d   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end else if (step_i) begin
      if (mplr_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q + C_CNT_ONE;
    end else if (negate_i && neg_q) begin
      prod_d = ~prod_q + C_ONE_P;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  assign prod_o    = prod_q;
  assign mplr_nz_o = |mplr_q;
  assign last_o    = (cnt_q == C_CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/mult32_seq_ctrl.sv
// ============================================================================
// Module      : mult32_seq_ctrl
// Description : Sequential WIDTHxWIDTH shift-and-add multiplier with its
//               controller. Accepts an operation on START in IDLE or DONE,
//               iterates one multiplier bit per cycle, applies the sign in a
//               fix-up cycle and pulses DONE. The product register drives
//               {HI,LO} continuously.
// Ports       : CLK, RST        - clock, synchronous active-high reset
//               START           - request (sampled in IDLE/DONE only)
//               SIGNED, A, B    - operand mode and operands, captured on START
//               BUSY            - high in RUN and FIX
//               DONE            - one-cycle completion pulse
//               HI, LO          - upper / lower product halves
// Config      : MULT_EARLY_TERM_EN - when defined, RUN ends as soon as no
//               multiplier bits remain set (product value unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult32_seq_ctrl
  import mult32_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  logic [1:0]         state_q, state_d;
  mult_ctrl_t         w_ctrl;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_mplr_nz;
  logic               w_last;
  logic               w_early_stop;

`ifdef MULT_EARLY_TERM_EN
  // Checked before the iteration: nothing left to add, so skip to FIX.
  assign w_early_stop = ~w_mplr_nz;
`else
  logic w_unused_mplr_nz;
  assign w_unused_mplr_nz = w_mplr_nz;
  assign w_early_stop     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    w_ctrl  = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          w_ctrl.load = 1'b1;
          state_d     = ST_RUN;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_early_stop) begin
          state_d = ST_FIX;
        end else begin
          w_ctrl.step = 1'b1;
          if (w_last) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        w_ctrl.negate = 1'b1;
        state_d       = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  mult32_datapath #(
    .WIDTH  (WIDTH),
    .PWIDTH (2*WIDTH)
  ) u_datapath (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (w_ctrl.load),
    .step_i    (w_ctrl.step),
    .negate_i  (w_ctrl.negate),
    .signed_i  (SIGNED),
    .a_i       (A),
    .b_i       (B),
    .prod_o    (w_prod),
    .mplr_nz_o (w_mplr_nz),
    .last_o    (w_last)
  );

  assign BUSY = is_busy_state(state_q);
  assign DONE = (state_q == ST_DONE);
  assign HI   = w_prod[2*WIDTH-1:WIDTH];
  assign LO   = w_prod[WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_mult32_seq_ctrl.sv
// ============================================================================
// Module      : tb_mult32_seq_ctrl
// Description : Self-checking bench for mult32_seq_ctrl. Expected products
//               and latencies are queued when an operation is issued and
//               compared when DONE is seen. Honours MULT_EARLY_TERM_EN for
//               the expected latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult32_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        SIGNED;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  mult32_seq_ctrl #(.WIDTH(32)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .SIGNED (SIGNED),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_mis = 0;
  int  g_n;      // edges since the accepting edge
  int  g_busy;   // cycles BUSY observed high since then

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = {{32{s & a[31]}}, a};
    eb = {{32{s & b[31]}}, b};
    return ea * eb;
  endfunction

  // Edges from the accepting edge until DONE is visible
  function automatic int exp_latency(input bit s, input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] mag;
    int          idx;
    mag = (s && b[31]) ? (~b + 32'd1) : b;
    if (mag == 32'd0) return 2;
    idx = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) idx = i;
    return (3 + idx < 33) ? 3 + idx : 33;
`else
    return 33;
`endif
  endfunction

  // One clock, sampled on the falling edge
  task automatic tick();
    if (BUSY) g_busy++;
    @(negedge CLK);
    g_n++;
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance
  task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
    sb_t e;
    e.prod = exp;
    e.lat  = exp_latency(s, b);
    sb.push_back(e);
    SIGNED = s; A = a; B = b; START = 1'b1;
    @(negedge CLK);
    START  = 1'b0;
    SIGNED = 1'($urandom);
    A      = $urandom;
    B      = $urandom;
    g_n    = 0;
    g_busy = 0;
  endtask

  task automatic wait_done();
    sb_t e;
    e = sb.pop_front();
    while (!DONE && g_n < 100) tick();
    if (!DONE) begin
      n_cmp++;
      n_mis++;
      $display("FAIL done_timeout: no DONE after %0d edges, expected %0d", g_n, e.lat);
    end else begin
      check("latency", 64'(g_n), 64'(e.lat));
      check("busy_cycles", 64'(g_busy), 64'(e.lat));
      check("hi", {32'd0, HI}, {32'd0, e.prod[63:32]});
      check("lo", {32'd0, LO}, {32'd0, e.prod[31:0]});
    end
  endtask

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic [31:0] ra, rb;
    bit rs;

    vecs[0] = '{1'b0, 32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'd2,          64'hFFFF_FFFF_0000_0000};
    vecs[4] = '{1'b1, 32'd7,          32'hFFFF_FFFD,  64'hFFFF_FFFF_FFFF_FFEB};
    vecs[5] = '{1'b0, 32'h0000_1234,  32'd0,          64'h0};
    vecs[6] = '{1'b0, 32'h0000_1234,  32'd1,          64'h0000_0000_0000_1234};
    vecs[7] = '{1'b0, 32'd5,          32'h8000_0000,  64'h0000_0002_8000_0000};
    vecs[8] = '{1'b1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[9] = '{1'b1, 32'hFFFF_FFFF,  32'h8000_0000,  64'h0000_0000_8000_0000};

    RST = 1'b1; START = 1'b0; SIGNED = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("reset_busy", {63'd0, BUSY}, 64'd0);
    check("reset_done", {63'd0, DONE}, 64'd0);
    check("reset_prod", {HI, LO}, 64'd0);
    @(negedge CLK);

    // Spec vectors, each followed by a check that DONE is a single pulse
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_done();
      tick();
      check("done_pulse", {63'd0, DONE}, 64'd0);
    end

    // Random operands against the behavioural model
    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      rb = (i < 4) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      start_op(rs, ra, rb, model(rs, ra, rb));
      wait_done();
      tick();
    end

    // START pulsed during RUN is ignored and not queued
    start_op(1'b0, 32'd3, 32'd5, 64'h0F);
    tick(); tick();
    SIGNED = 1'b0; A = 32'd100; B = 32'd100; START = 1'b1;
    tick();
    START = 1'b0;
    wait_done();
    tick();
    check("ignored_start_busy", {63'd0, BUSY}, 64'd0);
    check("ignored_start_done", {63'd0, DONE}, 64'd0);

    // Back-to-back: START held in the DONE cycle
    start_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 64'h0000_0002_FFFF_FFFD);
    wait_done();
    start_op(1'b1, 32'hFFFF_FFF0, 32'h0000_0011, 64'hFFFF_FFFF_FFFF_FEF0);
    check("b2b_busy", {63'd0, BUSY}, 64'd1);
    check("b2b_prod_cleared", {HI, LO}, 64'd0);
    wait_done();
    tick();

    // Reset in the middle of an operation
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    void'(sb.pop_back());
    while (g_n < 9) tick();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_busy", {63'd0, BUSY}, 64'd0);
    check("abort_done", {63'd0, DONE}, 64'd0);
    check("abort_prod", {HI, LO}, 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (DONE) dones++;
      @(negedge CLK);
    end
    check("abort_no_done", 64'(dones), 64'd0);

    // Fresh operation after the abort
    start_op(1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
